axi_rd_arb: RTL and testbench

- Two-requester arbiter sharing one AXI read port (AR + R channels) between masters s0 and s1.
- Sits in front of the register-slice/interconnect path. Serialises whole read transactions: one outstanding burst at a time, granted requester locked until the final R beat.
- Checks beat count against arlen and flags burst-length violations.

---
 rtl/axi_rd_arb.sv | 117 +++++++++++
 tb/tb_axi_rd_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: shares one AXI read port between two requesters, one whole burst at a time,
// and flags bursts whose beat count disagrees with arlen. Define AXI_RD_ARB_RR_EN for round-robin.
module axi_rd_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              s_arvalid,
    output logic [1:0]              s_arready,
    input  logic [2*ADDR_WIDTH-1:0] s_araddr,
    input  logic [15:0]             s_arlen,
    output logic [1:0]              s_rvalid,
    input  logic [1:0]              s_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic [USER_WIDTH-1:0]   s_ruser,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic [USER_WIDTH-1:0]   m_ruser,
    output logic                    grant_id,
    output logic                    busy,
    output logic                    len_err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic [8:0] beat_cnt;
    logic       win;
    logic       accept;
    logic       beat;
    logic       len_bad;

    always_comb begin
        win = s_arvalid[1] & ~s_arvalid[0];
`ifdef AXI_RD_ARB_RR_EN
        if (&s_arvalid) win = ~last_grant;
`endif
    end

`ifndef AXI_RD_ARB_RR_EN
    // Fixed priority never consults the grant history; it is kept for debug visibility only.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // No acceptance while reset is held, so a request cannot be swallowed by a reset edge.
    assign accept    = (state == ST_IDLE) && !rst && (|s_arvalid);
    assign s_arready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;

    assign busy     = (state != ST_IDLE);
    assign m_rready = (state == ST_DATA) && s_rready[grant_id];
    assign s_rvalid = ((state == ST_DATA) && m_rvalid) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign beat     = (state == ST_DATA) && m_rvalid && m_rready;
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;
    assign s_ruser  = m_ruser;

    // beat_cnt holds the index of the beat currently on the bus; index arlen must be the rlast beat.
    assign len_bad = m_rlast ? (beat_cnt != {1'b0, m_arlen}) : (beat_cnt == {1'b0, m_arlen});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            len_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        m_araddr  <= win ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
                        m_arlen   <= win ? s_arlen[15:8] : s_arlen[7:0];
                        grant_id  <= win;
                        beat_cnt  <= '0;
                        m_arvalid <= 1'b1;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (len_bad) len_err <= 1'b1;
                        if (m_rlast) begin
                            state      <= ST_IDLE;
                            last_grant <= grant_id;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: randomized bench for axi_rd_arb against a transaction-level reference model.
`timescale 1ns/1ps
module tb_axi_rd_arb;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int UW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      s_arvalid, s_arready;
    logic [2*AW-1:0] s_araddr;
    logic [15:0]     s_arlen;
    logic [1:0]      s_rvalid, s_rready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [UW-1:0]   s_ruser;
    logic            m_arvalid, m_arready;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic            m_rvalid, m_rready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [UW-1:0]   m_ruser;
    logic            grant_id, busy, len_err;

    // Reference model: pending requests per requester, grant history, sticky error.
    logic          pv[2];
    logic [AW-1:0] pa[2];
    logic [7:0]    pl[2];
    logic          last_g;
    logic          err_m;
    int errs = 0;
    int checks = 0;

    axi_rd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_ruser(s_ruser),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_ruser(m_ruser),
        .grant_id(grant_id), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
`ifdef AXI_RD_ARB_RR_EN
        if (pv[0] && pv[1]) return last_g ? 0 : 1;
`else
        if (pv[0] && pv[1]) return 0;
`endif
        return pv[1] ? 1 : 0;
    endfunction

    task automatic drive_req();
        s_arvalid = {pv[1], pv[0]};
        s_araddr  = {pa[1], pa[0]};
        s_arlen   = {pl[1], pl[0]};
    endtask

    task automatic req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        pv[i] = 1'b1;
        pa[i] = a;
        pl[i] = l;
    endtask

    task automatic refresh();
        for (int i = 0; i < 2; i++)
            if (!pv[i] && $urandom_range(0, 1) == 1) req(i, $urandom, 8'($urandom_range(0, 7)));
        if (!pv[0] && !pv[1]) req($urandom_range(0, 1), $urandom, 8'($urandom_range(0, 7)));
    endtask

    // One complete burst for the model's winner: nb=0 means a well-formed burst of arlen+1 beats.
    task automatic run_txn(input int arw, input int nb);
        int w, n, taken, cyc;
        logic [AW-1:0] a;
        logic [7:0] len;
        logic [1:0] ev;
        drive_req();
        w = pick();
        a = pa[w];
        len = pl[w];
        n = (nb == 0) ? int'(len) + 1 : nb;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("arready", s_arready, (w == 1) ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        pv[w] = 1'b0;
        drive_req();
        for (int c = 0; c <= arw; c++) begin
            m_arready = (c == arw);
            @(negedge clk);
            check("m_arvalid", m_arvalid, 1);
            check("m_araddr", m_araddr, a);
            check("m_arlen", m_arlen, len);
            check("grant_id", grant_id, w);
            check("addr_busy", busy, 1);
            check("addr_arready", s_arready, 0);
            @(posedge clk); #1;
        end
        m_arready = 1'b0;
        taken = 0;
        cyc = 0;
        while (taken < n) begin
            m_rvalid = ($urandom_range(0, 3) != 0);
            m_rlast  = m_rvalid && (taken == n - 1);
            m_rdata  = {$urandom, $urandom};
            m_rresp  = 2'($urandom);
            m_ruser  = UW'($urandom);
            s_rready = 2'($urandom);
            ev = m_rvalid ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            @(negedge clk);
            check("s_rvalid", s_rvalid, ev);
            check("m_rready", m_rready, s_rready[w]);
            check("data_arready", s_arready, 0);
            if (m_rvalid) begin
                check("s_rdata", s_rdata, m_rdata);
                check("s_rlast", s_rlast, m_rlast);
                check("s_rresp", s_rresp, m_rresp);
                check("s_ruser", s_ruser, m_ruser);
            end
            if (m_rvalid && s_rready[w]) taken++;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 400) begin
                check("data_timeout", taken, n);
                break;
            end
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 2'b00;
        if (n != int'(len) + 1) err_m = 1'b1;
        last_g = w[0];
        check("len_err", len_err, err_m);
        check("end_busy", busy, 0);
    endtask

    task automatic drain();
        while (pv[0] || pv[1]) run_txn($urandom_range(0, 2), 0);
    endtask

    task automatic reset_mid();
        req(0, 32'h3000, 8'd3);
        drive_req();
        @(negedge clk);
        check("rm_arready", s_arready, 2'b01);
        @(posedge clk); #1;
        pv[0] = 1'b0;
        req(1, 32'h4000, 8'd0);
        drive_req();
        m_arready = 1'b1;
        @(negedge clk);
        check("rm_m_arvalid", m_arvalid, 1);
        @(posedge clk); #1;
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 64'h1111;
        s_rready  = 2'b01;
        @(negedge clk);
        check("rm_beat1", s_rvalid, 2'b01);
        @(posedge clk); #1;
        m_rdata = 64'h2222;
        #2 rst = 1'b1;
        #1;
        check("rst_s_arready", s_arready, 0);
        check("rst_m_arvalid", m_arvalid, 0);
        check("rst_s_rvalid", s_rvalid, 0);
        check("rst_m_rready", m_rready, 0);
        check("rst_m_araddr", m_araddr, 0);
        check("rst_m_arlen", m_arlen, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_len_err", len_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_rvalid = 1'b0;
        s_rready = 2'b00;
        err_m  = 1'b0;
        last_g = 1'b1;
        req(0, 32'h5000, 8'd1);
        run_txn(0, 0);
        check("post_rst_grant", grant_id, 0);
        drain();
    endtask

    initial begin
        rst = 1'b1;
        s_arvalid = 2'b00; s_araddr = '0; s_arlen = '0; s_rready = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_ruser = '0;
        pv[0] = 1'b0; pv[1] = 1'b0; pa[0] = '0; pa[1] = '0; pl[0] = '0; pl[1] = '0;
        last_g = 1'b1;
        err_m  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_m_arvalid", m_arvalid, 0);
        check("reset_len_err", len_err, 0);
        check("reset_grant_id", grant_id, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", s_arready, 0);
        @(posedge clk); #1;

        req(0, 32'h1000, 8'd3);
        run_txn(0, 0);

        for (int k = 0; k < 4; k++) begin
            req(0, 32'h100, 8'd0);
            req(1, 32'h200, 8'd0);
            run_txn(0, 0);
        end
        drain();

        req(0, 32'h7000, 8'd7);
        run_txn(5, 0);

        req(0, 32'h8000, 8'd3);
        run_txn(0, 2);
        req(1, 32'h9000, 8'd2);
        run_txn(1, 0);

        req(1, 32'hA000, 8'd1);
        run_txn(0, 3);

        req(0, 32'hB000, 8'd0);
        run_txn(0, 0);
        reset_mid();

        for (int k = 0; k < 40; k++) begin
            refresh();
            run_txn($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
